// File: rtl/ds1302_time_ctrl.sv
// Purpose: sequences DS1302 time sets and periodic polls, then validates and publishes the BCD time.
// Latency: the trigger follows the IDLE decision by 1 cycle; time_valid or bcd_err arrives OP_WAIT+1 cycles after get_trig.
// Backpressure: none. Requests and poll wraps are held in pending flags until the next IDLE cycle.
module ds1302_time_ctrl #(
    parameter int unsigned sys_clk_freq     = 50_000_000,
    parameter int unsigned ds1302_clk_speed = 200_000,
    parameter int unsigned poll_hz          = 10
) (
    input  logic        sclk,
    input  logic        nrst,
    input  logic        set_req,
    input  logic [63:0] set_time,
    output logic        set_ack,
    output logic        set_trig,
    output logic        get_trig,
    output logic [63:0] bcd_time_set,
    input  logic [63:0] bcd_time_get,
    output logic [63:0] time_bcd,
    output logic        time_valid,
    output logic        sec_tick,
    output logic        bcd_err,
    output logic        busy
);

    localparam int unsigned POLL_CYCLES = sys_clk_freq / poll_hz;
    localparam int unsigned OP_WAIT     = 130 * (sys_clk_freq / ds1302_clk_speed) + 64;
    localparam int          PW          = $clog2(POLL_CYCLES);
    localparam int          WW          = $clog2(OP_WAIT);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(OP_WAIT - 1);

    typedef enum logic [1:0] {IDLE, SET_WAIT, GET_WAIT, CHECK} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] poll_cnt;
    logic [WW-1:0] wait_cnt;
    logic [63:0]   set_buf;
    logic          set_pend, poll_pend, have_valid;
    logic          poll_wrap, wait_done, bcd_ok;
    logic          take_set, take_poll, force_poll, latch_time;
    logic          set_trig_nxt, get_trig_nxt, set_ack_nxt;
    logic          valid_nxt, tick_nxt, err_nxt;

    assign poll_wrap = (poll_cnt == POLL_LAST);
    assign wait_done = (wait_cnt == WAIT_LAST);
    assign busy      = (state != IDLE);

    // Only the low nibble of bytes 0..6 is checked; the write-protect byte is ignored.
    always_comb begin
        bcd_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (bcd_time_get[8*i +: 4] > 4'd9) bcd_ok = 1'b0;
        end
    end

    always_comb begin
        state_nxt    = state;
        take_set     = 1'b0;
        take_poll    = 1'b0;
        force_poll   = 1'b0;
        latch_time   = 1'b0;
        set_trig_nxt = 1'b0;
        get_trig_nxt = 1'b0;
        set_ack_nxt  = 1'b0;
        valid_nxt    = 1'b0;
        tick_nxt     = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (set_pend) begin
                    take_set     = 1'b1;
                    set_trig_nxt = 1'b1;
                    state_nxt    = SET_WAIT;
                end else if (poll_pend) begin
                    take_poll    = 1'b1;
                    get_trig_nxt = 1'b1;
                    state_nxt    = GET_WAIT;
                end
            end
            SET_WAIT: begin
                if (wait_done) begin
                    set_ack_nxt = 1'b1;
                    force_poll  = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            GET_WAIT: begin
                if (wait_done) state_nxt = CHECK;
            end
            CHECK: begin
                if (bcd_ok) begin
                    latch_time = 1'b1;
                    valid_nxt  = 1'b1;
                    tick_nxt   = have_valid && (bcd_time_get[7:0] != time_bcd[7:0]);
                end else begin
                    err_nxt = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            poll_cnt     <= '0;
            wait_cnt     <= '0;
            set_buf      <= '0;
            set_pend     <= 1'b0;
            poll_pend    <= 1'b0;
            have_valid   <= 1'b0;
            bcd_time_set <= '0;
            time_bcd     <= '0;
            set_trig     <= 1'b0;
            get_trig     <= 1'b0;
            set_ack      <= 1'b0;
            time_valid   <= 1'b0;
            sec_tick     <= 1'b0;
            bcd_err      <= 1'b0;
        end else begin
            poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
            // The counter idles at 0, so it reads 0 in the trigger cycle.
            if ((state == SET_WAIT) || (state == GET_WAIT))
                wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
            else
                wait_cnt <= '0;

            if (set_req) begin
                set_buf  <= set_time & 64'h00FF_FFFF_FFFF_FFFF;
                set_pend <= 1'b1;
            end else if (take_set) begin
                set_pend <= 1'b0;
            end

            // A wrap in the same cycle as a poll launch is kept, not lost.
            if (poll_wrap || force_poll) poll_pend <= 1'b1;
            else if (take_poll)          poll_pend <= 1'b0;

            if (take_set) bcd_time_set <= set_buf;
            if (latch_time) begin
                time_bcd   <= bcd_time_get;
                have_valid <= 1'b1;
            end

            set_trig   <= set_trig_nxt;
            get_trig   <= get_trig_nxt;
            set_ack    <= set_ack_nxt;
            time_valid <= valid_nxt;
            sec_tick   <= tick_nxt;
            bcd_err    <= err_nxt;
        end
    end

endmodule
